// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Shared types for the CNN input path.
//   feeder_state_e : row feeder sequencing state (FILL, PRESENT)
//   value_t        : one channel value at the default value width
//   pixel_t        : one pixel, all channels, at the default channel count
// Modules carry their own VALUE_BITS / IN_CHANNELS parameters and default them
// from the DEFAULT_* localparams here.
// -----------------------------------------------------------------------------
package cnn_pkg;

   localparam int DEFAULT_VALUE_BITS  = 8;
   localparam int DEFAULT_IN_CHANNELS = 1;

   typedef enum logic {
      FILL    = 1'b0,
      PRESENT = 1'b1
   } feeder_state_e;

   typedef logic [DEFAULT_VALUE_BITS-1:0] value_t;
   typedef value_t [DEFAULT_IN_CHANNELS-1:0] pixel_t;

   // Counter width for a counter spanning 0..count-1; never narrower than 1.
   function automatic int counter_bits(input int count);
      return (count > 1) ? $clog2(count) : 1;
   endfunction

endpackage

// File: rtl/cnn_row_buffer.sv
// -----------------------------------------------------------------------------
// cnn_row_buffer
// One row of WIDTH pixels (IN_CHANNELS values each) held in registers.
// A pixel is written into column wr_col when wr_en is high; every column is
// visible in parallel on row.
//   clock   in  rising-edge clock
//   reset_n in  asynchronous active-low reset, clears every column
//   wr_en   in  write the pixel on wr_px into column wr_col
//   wr_col  in  target column, 0..WIDTH-1
//   wr_px   in  pixel to write
//   row     out full row contents, column 0 in the lowest slice
// -----------------------------------------------------------------------------
module cnn_row_buffer
   import cnn_pkg::*;
#(
   parameter int VALUE_BITS  = DEFAULT_VALUE_BITS,
   parameter int WIDTH       = 28,
   parameter int IN_CHANNELS = DEFAULT_IN_CHANNELS,
   localparam int COL_BITS   = counter_bits(WIDTH)
) (
   input  logic                                              clock,
   input  logic                                              reset_n,
   input  logic                                              wr_en,
   input  logic [COL_BITS-1:0]                               wr_col,
   input  logic [IN_CHANNELS-1:0][VALUE_BITS-1:0]            wr_px,
   output logic [WIDTH-1:0][IN_CHANNELS-1:0][VALUE_BITS-1:0] row
);

   logic [WIDTH-1:0]                               col_hit;
   logic [WIDTH-1:0][IN_CHANNELS-1:0][VALUE_BITS-1:0] cells_reg;

   // One-hot column decode of the write address.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_col_hit
      assign col_hit[gi] = wr_en && (wr_col == COL_BITS'(gi));
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cells_reg <= '0;
      end else begin
         for (int c = 0; c < WIDTH; c++) begin
            if (col_hit[c]) begin
               cells_reg[c] <= wr_px;
            end
         end
      end
   end

   assign row = cells_reg;

endmodule

// File: rtl/cnn_row_feeder.sv
// -----------------------------------------------------------------------------
// cnn_row_feeder
// Collects a pixel stream (one pixel, all channels, per beat) into rows of
// WIDTH pixels and hands each completed row to a cnn_layer input port.  The
// row index within an image is tracked so the final row of every image is
// flagged with row_last_o.
//
// Build option: define ROW_FEEDER_PINGPONG_EN for two row buffers (one fills
// while the other is presented, one row per WIDTH cycles sustained).  Without
// it a single buffer alternates between FILL and PRESENT (one row per
// WIDTH+1 cycles at best).
//
// Ports
//   clock_i       in  rising-edge clock
//   reset_ni      in  asynchronous active-low reset
//   px_i          in  pixel, all channels
//   px_valid_i    in  px_i valid
//   px_ready_o    out feeder takes a pixel this cycle
//   row_o         out assembled row (to the layer's in_row_i)
//   row_valid_o   out row_o complete (to in_row_valid_i)
//   row_accept_i  in  layer takes the row (from in_row_accept_o)
//   row_last_o    out presented row is row HEIGHT-1 of its image
//   image_done_o  out one-cycle pulse after the last row of an image transfers
// -----------------------------------------------------------------------------
module cnn_row_feeder
   import cnn_pkg::*;
#(
   parameter int VALUE_BITS  = DEFAULT_VALUE_BITS,
   parameter int WIDTH       = 28,
   parameter int HEIGHT      = 28,
   parameter int IN_CHANNELS = DEFAULT_IN_CHANNELS
) (
   input  logic                                              clock_i,
   input  logic                                              reset_ni,
   input  logic [IN_CHANNELS-1:0][VALUE_BITS-1:0]            px_i,
   input  logic                                              px_valid_i,
   output logic                                              px_ready_o,
   output logic [WIDTH-1:0][IN_CHANNELS-1:0][VALUE_BITS-1:0] row_o,
   output logic                                              row_valid_o,
   input  logic                                              row_accept_i,
   output logic                                              row_last_o,
   output logic                                              image_done_o
);

   localparam int COL_BITS = counter_bits(WIDTH);
   localparam int ROW_BITS = counter_bits(HEIGHT);
   localparam logic [COL_BITS-1:0] COL_MAX = COL_BITS'(WIDTH - 1);
   localparam logic [ROW_BITS-1:0] ROW_MAX = ROW_BITS'(HEIGHT - 1);

   logic [COL_BITS-1:0] col_reg;
   logic [ROW_BITS-1:0] row_reg;
   logic                px_ready_reg;
   logic                row_valid_reg;
   logic                row_last_reg;
   logic                image_done_reg;

   logic px_fire;    // pixel beat transfers at this edge
   logic row_fire;   // presented row transfers at this edge
   logic row_done;   // this beat completes the row being filled

   assign px_fire  = px_valid_i && px_ready_reg;
   assign row_fire = row_valid_reg && row_accept_i;
   assign row_done = px_fire && (col_reg == COL_MAX);

`ifdef ROW_FEEDER_PINGPONG_EN

   // full_reg[b]   : buffer b holds a complete row not yet taken by the layer.
   // fill_sel_reg  : buffer receiving pixels; always a non-full buffer while
   //                 px_ready_o is high.
   // present_sel   : buffer shown on row_o; it is the oldest full buffer, or
   //                 the one currently filling when neither is full.
   logic [1:0] full_reg;
   logic [1:0] full_next;
   logic       fill_sel_reg;
   logic       present_sel_reg;
   logic       present_sel_next;
   logic [ROW_BITS-1:0] row_next;
   logic [WIDTH-1:0][IN_CHANNELS-1:0][VALUE_BITS-1:0] buf_row [2];

   for (genvar gi = 0; gi < 2; gi++) begin : g_buf
      cnn_row_buffer #(
         .VALUE_BITS  (VALUE_BITS),
         .WIDTH       (WIDTH),
         .IN_CHANNELS (IN_CHANNELS)
      ) u_row_buffer (
         .clock   (clock_i),
         .reset_n (reset_ni),
         .wr_en   (px_fire && (fill_sel_reg == 1'(gi))),
         .wr_col  (col_reg),
         .wr_px   (px_i),
         .row     (buf_row[gi])
      );
   end

   // A transfer and a fill completion in the same cycle touch different
   // buffers, so both updates apply independently.  The row counter follows
   // the presented row.
   always_comb begin
      full_next        = full_reg;
      present_sel_next = present_sel_reg;
      row_next         = row_reg;
      if (row_fire) begin
         full_next[present_sel_reg] = 1'b0;
         present_sel_next           = ~present_sel_reg;
         row_next                   = (row_reg == ROW_MAX) ? '0 : row_reg + 1'b1;
      end
      if (row_done) begin
         full_next[fill_sel_reg] = 1'b1;
      end
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         full_reg        <= '0;
         fill_sel_reg    <= 1'b0;
         present_sel_reg <= 1'b0;
         col_reg         <= '0;
         row_reg         <= '0;
         px_ready_reg    <= 1'b0;
         row_valid_reg   <= 1'b0;
         row_last_reg    <= 1'b0;
         image_done_reg  <= 1'b0;
      end else begin
         full_reg        <= full_next;
         present_sel_reg <= present_sel_next;
         row_reg         <= row_next;
         if (px_fire) begin
            col_reg <= (col_reg == COL_MAX) ? '0 : col_reg + 1'b1;
         end
         if (row_done) begin
            fill_sel_reg <= ~fill_sel_reg;
         end
         // Outputs decoded from next state so they stay registered and the
         // buffer swap shows up without a bubble.
         px_ready_reg   <= ~(full_next[0] & full_next[1]);
         row_valid_reg  <= full_next[present_sel_next];
         row_last_reg   <= full_next[present_sel_next] && (row_next == ROW_MAX);
         image_done_reg <= row_fire && (row_reg == ROW_MAX);
      end
   end

   assign row_o = buf_row[present_sel_reg];

`else

   feeder_state_e state_reg;

   cnn_row_buffer #(
      .VALUE_BITS  (VALUE_BITS),
      .WIDTH       (WIDTH),
      .IN_CHANNELS (IN_CHANNELS)
   ) u_row_buffer (
      .clock   (clock_i),
      .reset_n (reset_ni),
      .wr_en   (px_fire),
      .wr_col  (col_reg),
      .wr_px   (px_i),
      .row     (row_o)
   );

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_reg      <= FILL;
         col_reg        <= '0;
         row_reg        <= '0;
         px_ready_reg   <= 1'b0;
         row_valid_reg  <= 1'b0;
         row_last_reg   <= 1'b0;
         image_done_reg <= 1'b0;
      end else begin
         image_done_reg <= 1'b0;
         case (state_reg)
            FILL: begin
               px_ready_reg <= 1'b1;
               if (px_fire) begin
                  if (col_reg == COL_MAX) begin
                     col_reg       <= '0;
                     state_reg     <= PRESENT;
                     px_ready_reg  <= 1'b0;
                     row_valid_reg <= 1'b1;
                     row_last_reg  <= (row_reg == ROW_MAX);
                  end else begin
                     col_reg <= col_reg + 1'b1;
                  end
               end
            end
            PRESENT: begin
               if (row_fire) begin
                  state_reg     <= FILL;
                  px_ready_reg  <= 1'b1;
                  row_valid_reg <= 1'b0;
                  row_last_reg  <= 1'b0;
                  if (row_reg == ROW_MAX) begin
                     row_reg        <= '0;
                     image_done_reg <= 1'b1;
                  end else begin
                     row_reg <= row_reg + 1'b1;
                  end
               end
            end
            default: state_reg <= FILL;
         endcase
      end
   end

`endif

   assign px_ready_o   = px_ready_reg;
   assign row_valid_o  = row_valid_reg;
   assign row_last_o   = row_last_reg;
   assign image_done_o = image_done_reg;

endmodule

// File: doc/cnn_row_feeder.md
Name: cnn_row_feeder

Overview:
- Sequencer in front of a cnn_layer input port.
- Accepts a pixel stream of one pixel per beat (all input channels), using a valid/ready handshake.
- Assembles each group of WIDTH pixels into a full row and presents it using the layer's row handshake (row valid, accept, last).
- Tracks the row index within an image, so the layer sees row_last_o on the final row of every image.

Parameters:
- VALUE_BITS, 8, bits per channel value.
- WIDTH, 28, pixels per row; must match the downstream layer's WIDTH.
- HEIGHT, 28, rows per image; must be 2 or more.
- IN_CHANNELS, 1, channels per pixel.

Ports:
- clock_i  in  1  single clock; all state updates on its rising edge.
- reset_ni  in  1  reset, asynchronous and active-low; clears all state immediately.
- px_i  in  [IN_CHANNELS][VALUE_BITS]  one pixel, all channels.
- px_valid_i  in  1  px_i holds valid data.
- px_ready_o  out  1  feeder can take a pixel; a beat transfers when px_valid_i and px_ready_o are both high at a rising edge.
- row_o  out  [WIDTH][IN_CHANNELS][VALUE_BITS]  assembled row; connects to the layer's in_row_i.
- row_valid_o  out  1  row_o is complete; connects to in_row_valid_i.
- row_accept_i  in  1  layer takes the row; connects to in_row_accept_o. A row transfers when row_valid_o and row_accept_i are both high at a rising edge.
- row_last_o  out  1  presented row is row HEIGHT-1 of its image; connects to in_row_last_i.
- image_done_o  out  1  one-cycle pulse in the cycle after the last row of an image transfers.

Behaviour:
- Reset values (reset_ni low):
  - row_o all zeros; row_valid_o=0; row_last_o=0; image_done_o=0.
  - px_ready_o=0 while reset_ni is low, then 1 from the first cycle after release.
  - Column counter=0, row counter=0, FSM=FILL.
- FSM states: FILL, PRESENT.
- FILL:
  - px_ready_o=1 and row_valid_o=0.
  - Each pixel beat writes buffer[col], then col increments.
  - A beat with col==WIDTH-1 sets col=0 and moves to PRESENT.
- PRESENT:
  - row_valid_o=1 and px_ready_o=0.
  - row_o and row_last_o stay stable until the row transfers; pixel beats are refused.
  - row_last_o = (row counter == HEIGHT-1), a registered decode.
  - On transfer: if row==HEIGHT-1, row resets to 0 and image_done_o pulses next cycle; otherwise row increments. FSM returns to FILL.
- Latency: row_valid_o rises in the cycle after the last pixel beat of the row transfers.
- Throughput: at best one row per WIDTH+1 cycles.
- px_valid_i deasserted mid-row: the column counter holds and partial row contents are kept; there is no timeout.
- row_accept_i while row_valid_o=0: ignored.
- Reset mid-row or mid-image: the partial row is discarded, the row counter returns to 0 and the next pixel starts row 0 of a new image.
- Counter widths: $clog2(WIDTH) bits for columns and $clog2(HEIGHT) bits for rows. Neither counter exceeds its maximum value.

Optional Feature:
- Macro ROW_FEEDER_PINGPONG_EN.
- Defined:
  - Two row buffers. One fills while the other is presented.
  - px_ready_o=0 only when both buffers are full.
  - If a fill completes in the same cycle the presented row transfers, the buffers swap and row_valid_o stays high with the new row, with no bubble. row_last_o updates to the new row's index in the same cycle.
  - Sustained throughput is one row per WIDTH cycles.
  - The row counter tracks the presented row; a separate fill-row counter is not needed.
- Undefined: the single-buffer FSM described above.

Decomposition:
- Shared package cnn_pkg holds:
  - the feeder_state_e enum {FILL, PRESENT};
  - typedef value_t = logic [VALUE_BITS-1:0] (VALUE_BITS as a package localparam default);
  - pixel_t, an array of IN_CHANNELS values.
- Sub-module cnn_row_buffer: one WIDTH x IN_CHANNELS register array with a write-enable and column index, instantiated twice when ROW_FEEDER_PINGPONG_EN is defined.

Test Plan (default parameters):
- Reset: hold reset_ni low for 3 cycles -> row_o all 0, row_valid_o=0, image_done_o=0; px_ready_o=1 from the first cycle after release.
- Single row: pixels 0..27 on consecutive cycles, row_accept_i=1 -> row_valid_o=1 in the cycle after beat 27; row_o[k][0]=k; row_last_o=0; row transfers at the next edge.
- Backpressure: row_accept_i=0 for 10 cycles after a full row -> row_valid_o held, row_o unchanged, px_ready_o=0 (single buffer); accept -> FILL resumes.
- Full image: 28 rows with pixel value (row*28+col) mod 256 -> row_last_o=1 only on row 27; one image_done_o pulse; next image's row 0 has row_last_o=0.
- Mid-row reset: reset after 13 beats of row 5 -> all outputs clear; the next 28 beats form row 0 with row_last_o=0.
- PINGPONG_EN: continuous pixels and row_accept_i=1 -> px_ready_o never drops after the first row; a new row is presented every 28 cycles with no row_valid_o gap.
